minterm_lut_bank: RTL
=====================

# minterm_lut_bank

Programmable, multi-channel sum-of-minterms evaluator. Each of `CH` channels holds a `2**N`-bit truth table. Each bit is one minterm, and channel output = 1 when the input vector's minterm bit is set. The block replaces fixed hard-wired minterm expressions: it registers the output and reloads tables at runtime through a serial configuration port with an atomic commit. It sits between the input-vector source and downstream sequential logic.

## Interface
- `N`, 4: input vector width; each table is `2**N` bits.
- `CH`, 2: channel count, ≥1.
- `RESET_TABLE`, `16'h38F0`: reset contents of every channel table. The default sets minterms 4,5,6,7,11,12,13.
- `clk` in 1: single clock; all logic is rising-edge.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: evaluation request.
- `in_x` in N: input vector. Bit 0 is the LSB of the minterm index.
- `out_valid` out 1: registered evaluation result valid.
- `out_y` out CH: per-channel result. Bit c is channel c.
- `cfg_start` in 1: begin table load for channel `cfg_ch`.
- `cfg_ch` in `CHW` (= `max(1,$clog2(CH))`): target channel.
- `cfg_valid` in 1: `cfg_bit` is valid this cycle.
- `cfg_bit` in 1: serial table bit, MSB (minterm `2**N-1`) first.
- `cfg_abort` in 1: discard the load in progress.
- `cfg_busy` out 1: loader not idle.
- `cfg_done` out 1: one-cycle pulse during the commit cycle.
- `hit_cnt` out `CH*16`: per-channel hit counters. Present only with `MINTERM_LUT_HITCNT_EN`.

## Operation
**Reset values**
- Every table = `RESET_TABLE`.
- `out_valid`=0, `out_y`=0, `cfg_busy`=0, `cfg_done`=0, `hit_cnt`=0, loader in IDLE, bit counter 0.

**Evaluation**
- When `in_valid`=1, the next edge sets `out_y[c] = table[c][in_x]` for all c, and `out_valid`=1.
- When `in_valid`=0, `out_valid`=0 and `out_y` holds its value.

**Loader FSM**
- IDLE:
  - `cfg_start` with `cfg_ch < CH` → LOAD. The block latches the channel and clears the shadow register and bit counter.
  - `cfg_start` with `cfg_ch >= CH` is ignored.
  - `cfg_valid` is ignored.
- LOAD:
  - Each `cfg_valid` cycle shifts `cfg_bit` into the shadow LSB (left shift) and increments the counter.
  - On the `2**N`-th accepted bit → COMMIT.
  - `cfg_start` is ignored.
  - `cfg_abort` → IDLE and the shadow is discarded. Abort wins over a simultaneous final bit.
- COMMIT (exactly one cycle):
  - `cfg_done`=1.
  - The shadow is written to `table[ch]` at the end of the cycle.
  - → IDLE.
  - `cfg_abort` in this cycle is ignored.
- `cfg_busy` = (state != IDLE).
- Other channels are never disturbed by a load.

**Arithmetic**
- Bit counter width is N+1.
- Hit counters are 16-bit and saturate at 65535, with no wrap.

## Timing
- Evaluation latency: 1 cycle from `in_valid` to `out_valid`. Full throughput, one evaluation per cycle.
- Evaluations use the table as it was at the start of the cycle:
  - An evaluation in the COMMIT cycle sees the old table.
  - An evaluation in the following cycle sees the new table.
- `cfg_start` at edge t makes `cfg_busy`=1 from t+1.
- If the final bit is accepted in cycle k:
  - COMMIT and `cfg_done` occur in cycle k+1.
  - `cfg_busy`=0 in cycle k+2.
- `cfg_abort` in cycle k makes `cfg_busy`=0 in k+1.
- `rst` mid-load returns the loader to IDLE and restores every table to `RESET_TABLE`. No partial commit occurs.

## Configuration
- `MINTERM_LUT_HITCNT_EN` defined:
  - Adds `hit_cnt`. Counter c increments when `in_valid`=1 and `table[c][in_x]`=1, counting the same cycle the result is registered.
  - Counters saturate.
  - Counters are cleared only by `rst`.
- Undefined: the port, counters and logic are absent. All other behaviour is identical.

## Structure
- Package `minterm_lut_pkg` holds:
  - the loader state enum (IDLE, LOAD, COMMIT);
  - the default table constant `16'h38F0`;
  - the hit-counter width constant (16).
- Sub-module `minterm_lut_loader` contains the FSM, shadow register, bit counter, channel latch, and the `cfg_busy`/`cfg_done` outputs. It exports a commit strobe, the channel index and the shadow value.
- The top level holds the table array, the evaluation register and the optional counters.

## Test plan
- Reset, then sweep `in_x`=0..15 with `in_valid`=1 → `out_y[0]`=1 exactly for 4,5,6,7,11,12,13, one cycle later each. `out_y[1]` is the same.
- Load ch1 with `16'h8001`, 16 bits MSB first → `cfg_done` pulse one cycle after the 16th bit. Then `in_x`=0 and 15 → `out_y[1]`=1 and the other inputs give 0. Ch0 is unchanged.
- Start a load on ch0, shift 7 bits, assert `cfg_abort` → `cfg_busy` falls next cycle. `in_x`=4 → `out_y[0]`=1, so the table is unchanged.
- Load ch0 with 0 and evaluate `in_x`=5 in the COMMIT cycle and in the next cycle → results 1, then 0.
- Assert `rst` after 10 load bits → `cfg_busy`=0 and tables = `16'h38F0`. A new `cfg_start` is accepted normally.
- With `MINTERM_LUT_HITCNT_EN`: 20 evaluations of `in_x`=5 → `hit_cnt` ch0 = 20, ch1 = 20. Forcing 70000 hits → 65535.

Source files
------------

// File: rtl/minterm_lut_pkg.sv
// Shared types and constants for the minterm LUT bank.
// Optional feature macro: MINTERM_LUT_HITCNT_EN (per-channel hit counters).
package minterm_lut_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_COMMIT = 2'd2
    } load_state_t;

    localparam logic [15:0] DEFAULT_TABLE = 16'h38F0;  // minterms 4,5,6,7,11,12,13
    localparam int          HIT_W         = 16;

endpackage

// File: rtl/minterm_lut_bank_if.sv
// Evaluation and configuration bus of the minterm LUT bank.
// Optional feature macro: MINTERM_LUT_HITCNT_EN adds hit_cnt.
interface minterm_lut_bank_if #(
    parameter int N  = 4,
    parameter int CH = 2
);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

    logic           in_valid;
    logic [N-1:0]   in_x;
    logic           out_valid;
    logic [CH-1:0]  out_y;
    logic           cfg_start;
    logic [CHW-1:0] cfg_ch;
    logic           cfg_valid;
    logic           cfg_bit;
    logic           cfg_abort;
    logic           cfg_busy;
    logic           cfg_done;
`ifdef MINTERM_LUT_HITCNT_EN
    logic [CH*16-1:0] hit_cnt;

    modport master (output in_valid, in_x, cfg_start, cfg_ch, cfg_valid, cfg_bit, cfg_abort,
                    input  out_valid, out_y, cfg_busy, cfg_done, hit_cnt);
    modport slave  (input  in_valid, in_x, cfg_start, cfg_ch, cfg_valid, cfg_bit, cfg_abort,
                    output out_valid, out_y, cfg_busy, cfg_done, hit_cnt);
`else
    modport master (output in_valid, in_x, cfg_start, cfg_ch, cfg_valid, cfg_bit, cfg_abort,
                    input  out_valid, out_y, cfg_busy, cfg_done);
    modport slave  (input  in_valid, in_x, cfg_start, cfg_ch, cfg_valid, cfg_bit, cfg_abort,
                    output out_valid, out_y, cfg_busy, cfg_done);
`endif

endinterface

// File: rtl/minterm_lut_loader.sv
// Serial table loader: shifts a table in MSB first, then commits it in one cycle.
//
//   state     | meaning
//   ----------+------------------------------------------------
//   ST_IDLE   | waiting for cfg_start on a valid channel
//   ST_LOAD   | shifting bits into the shadow register
//   ST_COMMIT | one cycle; shadow is written to the table at its end
module minterm_lut_loader
    import minterm_lut_pkg::*;
#(
    parameter int N   = 4,
    parameter int CH  = 2,
    parameter int CHW = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_start,
    input  logic [CHW-1:0]    i_ch,
    input  logic              i_valid,
    input  logic              i_bit,
    input  logic              i_abort,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_commit,
    output logic [CHW-1:0]    o_ch,
    output logic [2**N-1:0]   o_shadow
);
    load_state_t    r_state;
    load_state_t    w_next;
    logic [N:0]     r_cnt;
    logic [CHW-1:0] r_ch;
    logic [2**N-1:0] r_shadow;
    logic           w_ch_ok;
    logic           w_last;

    assign w_ch_ok = (32'(i_ch) < CH);
    assign w_last  = (r_cnt == (N+1)'(2**N - 1));

    // Next-state decode; abort takes priority over the final bit.
    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:   if (i_start && w_ch_ok) w_next = ST_LOAD;
            ST_LOAD: begin
                if (i_abort)                 w_next = ST_IDLE;
                else if (i_valid && w_last)  w_next = ST_COMMIT;
            end
            ST_COMMIT: w_next = ST_IDLE;
            default:   w_next = ST_IDLE;
        endcase
    end

    // State register plus shadow/counter/channel datapath.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_cnt    <= '0;
            r_ch     <= '0;
            r_shadow <= '0;
        end else begin
            r_state <= w_next;
            case (r_state)
                ST_IDLE: begin
                    if (i_start && w_ch_ok) begin
                        r_ch     <= i_ch;
                        r_shadow <= '0;
                        r_cnt    <= '0;
                    end
                end
                ST_LOAD: begin
                    if (i_abort) begin
                        r_shadow <= '0;
                        r_cnt    <= '0;
                    end else if (i_valid) begin
                        r_shadow <= {r_shadow[2**N-2:0], i_bit};
                        r_cnt    <= r_cnt + 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy   = (r_state != ST_IDLE);
    assign o_done   = (r_state == ST_COMMIT);
    assign o_commit = (r_state == ST_COMMIT);
    assign o_ch     = r_ch;
    assign o_shadow = r_shadow;

endmodule

// File: rtl/minterm_lut_bank.sv
// Multi-channel programmable sum-of-minterms evaluator with registered output.
// Optional feature macro: MINTERM_LUT_HITCNT_EN (saturating per-channel hit counters).
module minterm_lut_bank
    import minterm_lut_pkg::*;
#(
    parameter int                N           = 4,
    parameter int                CH          = 2,
    parameter logic [2**N-1:0]   RESET_TABLE = (2**N)'(DEFAULT_TABLE)
) (
    input  logic               clk,
    input  logic               rst,
    minterm_lut_bank_if.slave  bus
);
    localparam int CHW = (CH > 1) ? $clog2(CH) : 1;

    logic [2**N-1:0] r_table [CH];
    logic            r_out_valid;
    logic [CH-1:0]   r_out_y;
    logic            w_commit;
    logic [CHW-1:0]  w_ch;
    logic [2**N-1:0] w_shadow;
    logic [CH-1:0]   w_hit;

    minterm_lut_loader #(.N(N), .CH(CH), .CHW(CHW)) u_loader (
        .clk      (clk),
        .rst      (rst),
        .i_start  (bus.cfg_start),
        .i_ch     (bus.cfg_ch),
        .i_valid  (bus.cfg_valid),
        .i_bit    (bus.cfg_bit),
        .i_abort  (bus.cfg_abort),
        .o_busy   (bus.cfg_busy),
        .o_done   (bus.cfg_done),
        .o_commit (w_commit),
        .o_ch     (w_ch),
        .o_shadow (w_shadow)
    );

    // Per-channel lookup of the current input vector in the live tables.
    always_comb begin
        w_hit = '0;
        for (int c = 0; c < CH; c++) w_hit[c] = r_table[c][bus.in_x];
    end

    // Table storage; the committed shadow lands at the end of the commit cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) r_table[c] <= RESET_TABLE;
        end else if (w_commit) begin
            for (int c = 0; c < CH; c++)
                if (w_ch == CHW'(c)) r_table[c] <= w_shadow;
        end
    end

    // Evaluation register; out_y holds when no request is present.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_y     <= '0;
        end else begin
            r_out_valid <= bus.in_valid;
            if (bus.in_valid) r_out_y <= w_hit;
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.out_y     = r_out_y;

`ifdef MINTERM_LUT_HITCNT_EN
    logic [HIT_W-1:0] r_hit [CH];

    // Saturating hit counters, counted on the same edge the result is registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int c = 0; c < CH; c++) r_hit[c] <= '0;
        end else if (bus.in_valid) begin
            for (int c = 0; c < CH; c++)
                if (w_hit[c] && (r_hit[c] != '1)) r_hit[c] <= r_hit[c] + 1'b1;
        end
    end

    for (genvar g = 0; g < CH; g++) begin : g_hit
        assign bus.hit_cnt[g*HIT_W +: HIT_W] = r_hit[g];
    end
`endif

endmodule
